// File: rtl/cacheline_adaptor_p_pkg.sv
// Shared types and constants for the cache line <-> memory burst adaptor.
package cacheline_adaptor_p_pkg;

  localparam int S_LINE   = 256;
  localparam int S_BURST  = 64;
  localparam int S_OFFSET = 5;
  localparam int BEATS    = S_LINE / S_BURST;

  typedef logic [S_BURST-1:0] beat_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // Line-align a byte address by clearing the offset bits.
  function automatic logic [31:0] line_addr(input logic [31:0] addr);
    logic [31:0] mask;
    mask = ~((32'd1 << S_OFFSET) - 32'd1);
    return addr & mask;
  endfunction

endpackage

// File: rtl/cacheline_adaptor_p.sv
// Converts 256-bit cache line refills/writebacks into 4-beat 64-bit memory bursts.
// state | meaning: IDLE wait for request; READ gather beats; WRITE send beats; DONE pulse resp_o.
module cacheline_adaptor_p
  import cacheline_adaptor_p_pkg::*;
#(
  parameter int s_line   = S_LINE,
  parameter int s_burst  = S_BURST,
  parameter int s_offset = S_OFFSET
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [31:0]       address_i,
  input  logic [s_line-1:0] line_i,
  output logic [s_line-1:0] line_o,
  output logic              resp_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]       address_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int beats = s_line / s_burst;
  localparam int cw    = $clog2(beats);
  localparam logic [cw-1:0] last_beat = cw'(beats - 1);

  adaptor_state_t state, state_n;
  logic [cw-1:0]     count;
  logic [cw-1:0]     count_nx;
  logic [s_line-1:0] line_q;

  assign count_nx = count + 1'b1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: begin
        if (write_i)     state_n = WRITE;
        else if (read_i) state_n = READ;
      end
      READ, WRITE: begin
        if (resp_i && (count == last_beat)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Handshake outputs decode from state alone so they never glitch on inputs.
  assign read_o  = (state == READ);
  assign write_o = (state == WRITE);
  assign resp_o  = (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count     <= '0;
      line_q    <= '0;
      line_o    <= '0;
      burst_o   <= '0;
      address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_i || read_i) begin
            address_o <= line_addr(address_i);
            count     <= '0;
          end
          if (write_i) begin
            line_q  <= line_i;
            burst_o <= line_i[s_burst-1:0];
          end
        end
        READ: begin
          if (resp_i) begin
            line_o[int'(count)*s_burst +: s_burst] <= burst_i;
            count <= count_nx;
          end
        end
        WRITE: begin
          // Preload the next beat so it is on the bus the cycle after the strobe.
          if (resp_i) begin
            burst_o <= line_q[int'(count_nx)*s_burst +: s_burst];
            count   <= count_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor_p.sv
// Self-checking bench for cacheline_adaptor_p: directed and randomized refills/writebacks.
module tb_cacheline_adaptor_p;

  logic         clk;
  logic         rst;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int n_cmp = 0;
  int n_bad = 0;
  logic [255:0] model_line;

  cacheline_adaptor_p dut (
    .clk(clk), .rst(rst), .read_i(read_i), .write_i(write_i),
    .address_i(address_i), .line_i(line_i), .line_o(line_o), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Refill: starts at a negedge with the adaptor idle, ends at a negedge in IDLE.
  task automatic do_read(input logic [31:0] addr, input logic [15:0] pat, input int pat_len,
                         input logic [255:0] data, input bit fixed);
    logic [255:0] exp_line;
    logic [63:0]  b;
    logic         beat;
    int k;
    int cyc;
    exp_line = model_line;
    read_i    = 1'b1;
    address_i = addr;
    @(negedge clk);
    chk("rd_addr", address_o, addr & 32'hFFFF_FFE0);
    address_i = $urandom;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      chk("rd_req", read_o, 1);
      chk("rd_early_resp", resp_o, 0);
      if (pat_len > 0) beat = (cyc < pat_len) ? pat[cyc] : 1'b1;
      else             beat = ($urandom_range(0, 99) >= 30) || (cyc > 40);
      b = fixed ? data[k*64 +: 64] : {$urandom, $urandom};
      burst_i = b;
      resp_i  = beat;
      if (beat) begin
        exp_line[k*64 +: 64] = b;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    resp_i  = 1'b0;
    burst_i = {$urandom, $urandom};
    chk("rd_resp", resp_o, 1);
    chk("rd_req_off", read_o, 0);
    chk("rd_line", line_o, exp_line);
    read_i = 1'b0;
    model_line = exp_line;
    @(negedge clk);
    chk("rd_resp_pulse", resp_o, 0);
    chk("rd_idle", read_o, 0);
    chk("rd_line_hold", line_o, model_line);
  endtask

  // Writeback: same entry/exit convention; keep_read leaves read_i asserted.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line, input bit keep_read);
    logic beat;
    int k;
    int cyc;
    write_i   = 1'b1;
    line_i    = line;
    address_i = addr;
    @(negedge clk);
    chk("wr_addr", address_o, addr & 32'hFFFF_FFE0);
    line_i    = rand_line();
    address_i = $urandom;
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 64) begin
      chk("wr_req", write_o, 1);
      chk("wr_not_rd", read_o, 0);
      chk("wr_early_resp", resp_o, 0);
      chk("wr_beat", burst_o, line[k*64 +: 64]);
      beat   = ($urandom_range(0, 99) >= 30) || (cyc > 40);
      resp_i = beat;
      burst_i = {$urandom, $urandom};
      if (beat) k++;
      @(negedge clk);
      cyc++;
    end
    resp_i = 1'b0;
    chk("wr_resp", resp_o, 1);
    chk("wr_req_off", write_o, 0);
    chk("wr_line_untouched", line_o, model_line);
    write_i = 1'b0;
    if (!keep_read) read_i = 1'b0;
    @(negedge clk);
    chk("wr_resp_pulse", resp_o, 0);
    chk("wr_idle", write_o, 0);
  endtask

  initial begin
    logic [255:0] dir_line;
    logic [255:0] wb_line;
    rst = 1'b0; read_i = 1'b1; write_i = 1'b0; address_i = 32'h0000_1234;
    line_i = '0; burst_i = '0; resp_i = 1'b0;
    model_line = '0;
    dir_line = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    wb_line  = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};

    repeat (3) @(negedge clk);
    chk("rst_read_o", read_o, 0);
    chk("rst_write_o", write_o, 0);
    chk("rst_resp_o", resp_o, 0);
    chk("rst_line_o", line_o, 0);
    chk("rst_burst_o", burst_o, 0);
    chk("rst_address_o", address_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_read", read_o, 1);
    chk("rst_release_addr", address_o, 32'h0000_1220);
    rst = 1'b0;
    read_i = 1'b0;
    #1;
    chk("rst_abort_read", read_o, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Directed refill, no stalls, then with stalls 1,0,0,1,1,0,1.
    do_read(32'h0000_1234, 16'h000F, 4, dir_line, 1'b1);
    chk("dir_line_nostall", line_o, dir_line);
    do_read(32'h0000_1234, 16'b1011001, 7, dir_line, 1'b1);
    chk("dir_line_stall", line_o, dir_line);

    do_write(32'hABCD_0047, wb_line, 1'b0);

    // Simultaneous request: writeback first, then the refill from the held read_i.
    read_i = 1'b1;
    do_write(32'h0000_5678, rand_line(), 1'b1);
    do_read(32'h0000_5678, 16'h0, 0, '0, 1'b0);

    // Reset mid-refill after two beats.
    read_i = 1'b1; address_i = 32'h00FF_0010;
    @(negedge clk);
    resp_i = 1'b1; burst_i = 64'hDEAD_BEEF_0000_0001;
    @(negedge clk);
    burst_i = 64'hDEAD_BEEF_0000_0002;
    @(negedge clk);
    resp_i = 1'b0;
    rst = 1'b0;
    read_i = 1'b0;
    #1;
    chk("mid_rst_read_o", read_o, 0);
    chk("mid_rst_resp_o", resp_o, 0);
    chk("mid_rst_line_o", line_o, 0);
    chk("mid_rst_address_o", address_o, 0);
    chk("mid_rst_burst_o", burst_o, 0);
    model_line = '0;
    @(negedge clk);
    chk("mid_rst_no_resp", resp_o, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_idle", read_o, 0);
    do_read(32'h00FF_0010, 16'h0, 0, '0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 1) == 1) do_read($urandom, 16'h0, 0, '0, 1'b0);
      else                           do_write($urandom, rand_line(), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
